// File: rtl/aes_rom_fetch_ctrl_pkg.sv
// Shared definitions for the plaintext/key ROM fetch sequencer: width defines and FSM state encoding.
// The optional FETCH_LOOP_EN macro (used by the top) makes runs wrap continuously instead of stopping.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 4
`endif
`ifndef TEXT_WIDTH
`define TEXT_WIDTH 128
`endif
`ifndef KEY_WIDTH
`define KEY_WIDTH 128
`endif
`ifndef MEMORY_SIZE
`define MEMORY_SIZE 4
`endif

package aes_rom_fetch_ctrl_pkg;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADDR  = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_VALID = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam int ADDR_W_DEF     = `ADDR_WIDTH;
  localparam int TEXT_W_DEF     = `TEXT_WIDTH;
  localparam int KEY_W_DEF      = `KEY_WIDTH;
  localparam int NUM_BLOCKS_DEF = `MEMORY_SIZE;
endpackage

// File: rtl/aes_rom_fetch_ctrl.sv
// Steps the ROM address through NUM_BLOCKS entries and hands each registered text/key to the AES core.
// Define FETCH_LOOP_EN to wrap back to address 0 after the last block instead of parking in DONE.
module aes_rom_fetch_ctrl
  import aes_rom_fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int TEXT_W     = TEXT_W_DEF,
  parameter int KEY_W      = KEY_W_DEF,
  parameter int NUM_BLOCKS = NUM_BLOCKS_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              abort_i,
  output logic [ADDR_W-1:0] pc_o,
  input  logic [TEXT_W-1:0] rom_text_i,
  input  logic [KEY_W-1:0]  rom_key_i,
  output logic [TEXT_W-1:0] text_o,
  output logic [KEY_W-1:0]  key_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W:0]   blk_cnt_o,
  output logic [2:0]        dbg_state_o
);
  // Handshake: text_o/key_o are stable while valid_o=1 and are consumed at the posedge where
  // valid_o & ready_i; ready_i is don't-care while valid_o=0; abort_i cancels a pending transfer.

  localparam logic [ADDR_W:0] NB_C = (ADDR_W+1)'(NUM_BLOCKS);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W:0]   blk_cnt_q, blk_cnt_d;
  logic [TEXT_W-1:0] text_q, text_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic [ADDR_W:0]   blk_inc;
  logic              last_blk;

  assign blk_inc  = blk_cnt_q + 1'b1;
  assign last_blk = (blk_inc == NB_C);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      blk_cnt_q <= '0;
      text_q    <= '0;
      key_q     <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      blk_cnt_q <= blk_cnt_d;
      text_q    <= text_d;
      key_q     <= key_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: if (start_i) state_d = ST_ADDR;
        ST_ADDR:          state_d = ST_WAIT;
        ST_WAIT:          state_d = ST_VALID;
        ST_VALID: begin
          if (ready_i) begin
`ifdef FETCH_LOOP_EN
            state_d = ST_ADDR;
`else
            state_d = last_blk ? ST_DONE : ST_ADDR;
`endif
          end
        end
        default:          state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    pc_d      = pc_q;
    blk_cnt_d = blk_cnt_q;
    text_d    = text_q;
    key_d     = key_q;
    valid_d   = valid_q;
`ifdef FETCH_LOOP_EN
    done_d    = 1'b0;  // single-cycle pulse per wrap
`else
    done_d    = done_q;
`endif
    if (abort_i) begin
      valid_d = 1'b0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            pc_d      = '0;
            blk_cnt_d = '0;
            done_d    = 1'b0;
          end
        end
        ST_WAIT: begin
          text_d  = rom_text_i;
          key_d   = rom_key_i;
          valid_d = 1'b1;
        end
        ST_VALID: begin
          if (ready_i) begin
            valid_d   = 1'b0;
            blk_cnt_d = blk_inc;
            if (last_blk) begin
              done_d = 1'b1;
`ifdef FETCH_LOOP_EN
              pc_d      = '0;
              blk_cnt_d = '0;
`endif
            end else begin
              pc_d = pc_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy_o      = (state_q == ST_ADDR) || (state_q == ST_WAIT) || (state_q == ST_VALID);
    pc_o        = pc_q;
    blk_cnt_o   = blk_cnt_q;
    text_o      = text_q;
    key_o       = key_q;
    valid_o     = valid_q;
    done_o      = done_q;
    dbg_state_o = state_q;
  end
endmodule

// File: tb/tb_aes_rom_fetch_ctrl.sv
// Directed bench for aes_rom_fetch_ctrl with a negedge-read ROM model and an expected-text queue.
module tb_aes_rom_fetch_ctrl;
  import aes_rom_fetch_ctrl_pkg::*;

  localparam int AW = 4;
`ifdef FETCH_LOOP_EN
  localparam int NB = 2;
`else
  localparam int NB = 4;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start, abort, ready;
  logic [AW-1:0]  pc;
  logic [127:0]   rom_text, rom_key, text, key;
  logic           valid, busy, done;
  logic [AW:0]    blk_cnt;
  logic [2:0]     state;

  logic [127:0] exp_q[$];
  int vectors = 0;
  int errors  = 0;

  aes_rom_fetch_ctrl #(.ADDR_W(AW), .TEXT_W(128), .KEY_W(128), .NUM_BLOCKS(NB)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .abort_i(abort), .pc_o(pc),
    .rom_text_i(rom_text), .rom_key_i(rom_key), .text_o(text), .key_o(key),
    .valid_o(valid), .ready_i(ready), .busy_o(busy), .done_o(done),
    .blk_cnt_o(blk_cnt), .dbg_state_o(state)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] rom_key_f(input logic [AW-1:0] a);
    return 128'hA5A5_A5A5_0000_0000_0000_0000_0000_0000 ^ {124'd0, ~a};
  endfunction

  always @(negedge clk) begin
    rom_text <= {124'd0, pc};
    rom_key  <= rom_key_f(pc);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_run();
    for (int i = 0; i < NB; i++) exp_q.push_back(128'(i));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic chk_block(input string tag);
    logic [127:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 128'(exp_q.size()), 128'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_valid"}, 128'(valid), 128'd1);
      chk({tag, "_text"}, text, e);
      chk({tag, "_key"}, key, rom_key_f(e[AW-1:0]));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b0;
    #12 rst_n = 1'b1;
    step();
    chk("rst_state", 128'(state), 128'(ST_IDLE));
    chk("rst_pc", 128'(pc), 128'd0);
    chk("rst_text", text, 128'd0);
    chk("rst_key", key, 128'd0);
    chk("rst_valid", 128'(valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_blk", 128'(blk_cnt), 128'd0);

`ifndef FETCH_LOOP_EN
    // Full run with ready held high: latency 3, spacing 3.
    ready = 1'b1;
    push_run();
    pulse_start();
    chk("lat_c1_valid", 128'(valid), 128'd0);
    chk("lat_c1_busy", 128'(busy), 128'd1);
    step();
    chk("lat_c2_valid", 128'(valid), 128'd0);
    step();
    for (int i = 0; i < NB; i++) begin
      chk_block($sformatf("run_blk%0d", i));
      chk($sformatf("run_pc%0d", i), 128'(pc), 128'(i));
      step();
      chk($sformatf("run_drop%0d", i), 128'(valid), 128'd0);
      chk($sformatf("run_cnt%0d", i), 128'(blk_cnt), 128'(i + 1));
      if (i < NB - 1) begin
        step();
        chk($sformatf("run_gap%0d", i), 128'(valid), 128'd0);
        step();
      end
    end
    chk("run_done", 128'(done), 128'd1);
    chk("run_state", 128'(state), 128'(ST_DONE));
    chk("run_busy", 128'(busy), 128'd0);
    chk("run_pc_last", 128'(pc), 128'd3);
    step();
    chk("run_done_hold", 128'(done), 128'd1);

    // Restart from DONE, then backpressure on block 1 with a stray start_i.
    push_run();
    pulse_start();
    chk("restart_done_clr", 128'(done), 128'd0);
    chk("restart_pc", 128'(pc), 128'd0);
    chk("restart_cnt", 128'(blk_cnt), 128'd0);
    step(); step();
    chk_block("restart_blk0");
    step();
    ready = 1'b0;
    step(); step();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_valid%0d", k), 128'(valid), 128'd1);
      chk($sformatf("bp_text%0d", k), text, 128'd1);
      if (k == 2) begin
        start = 1'b1;
        step();
        start = 1'b0;
      end else begin
        step();
      end
    end
    chk("bp_pc", 128'(pc), 128'd1);
    chk("bp_cnt", 128'(blk_cnt), 128'd1);
    chk_block("bp_blk1");
    ready = 1'b1;
    step();
    chk("bp_accept_valid", 128'(valid), 128'd0);
    chk("bp_accept_cnt", 128'(blk_cnt), 128'd2);
    step(); step();
    chk_block("pre_abort_blk2");
    chk("pre_abort_pc", 128'(pc), 128'd2);

    // Abort wins over the handshake in the same cycle.
    abort = 1'b1;
    step();
    abort = 1'b0;
    exp_q.delete();
    chk("abort_state", 128'(state), 128'(ST_IDLE));
    chk("abort_valid", 128'(valid), 128'd0);
    chk("abort_cnt", 128'(blk_cnt), 128'd2);
    chk("abort_pc", 128'(pc), 128'd2);
    chk("abort_done", 128'(done), 128'd0);
    chk("abort_busy", 128'(busy), 128'd0);
    step();
    chk("abort_stay", 128'(state), 128'(ST_IDLE));

    // Asynchronous reset while VALID is pending.
    ready = 1'b0;
    push_run();
    pulse_start();
    step(); step();
    chk_block("prereset_blk0");
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", 128'(valid), 128'd0);
    chk("arst_state", 128'(state), 128'(ST_IDLE));
    chk("arst_text", text, 128'd0);
    chk("arst_key", key, 128'd0);
    chk("arst_busy", 128'(busy), 128'd0);
    rst_n = 1'b1;
    exp_q.delete();
    step();
    chk("arst_after_state", 128'(state), 128'(ST_IDLE));
    chk("arst_after_pc", 128'(pc), 128'd0);
`else
    // Looping run: 0,1,0,1,... with a one-cycle done pulse per wrap.
    ready = 1'b1;
    pulse_start();
    step(); step();
    for (int w = 0; w < 3; w++) begin
      push_run();
      for (int i = 0; i < NB; i++) begin
        chk_block($sformatf("loop_w%0d_b%0d", w, i));
        step();
        chk($sformatf("loop_cnt_w%0d_b%0d", w, i), 128'(blk_cnt), 128'((i + 1) % NB));
        chk($sformatf("loop_done_w%0d_b%0d", w, i), 128'(done), 128'(i == NB - 1));
        step();
        chk($sformatf("loop_donepulse_w%0d_b%0d", w, i), 128'(done), 128'd0);
        step();
      end
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("loop_abort_state", 128'(state), 128'(ST_IDLE));
    chk("loop_abort_valid", 128'(valid), 128'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
